light_dp: RTL and testbench
===========================

# light_dp

Datapath stage for the traffic-light controller: consumes the controller's one-hot `curr_state` and `dp_cnt_rst`, produces the `done_state` vector that the controller uses to advance phases, and drives the R/G/Y lamps. Holds a phase counter, per-phase duration registers and a shadow bank for run-time reprogramming that is committed only at a cycle boundary. Sits in a closed loop with the controller: `done_state` feeds it and `curr_state`/`dp_cnt_rst` come back.

## Interface

- `CNT_W`, 10: counter and duration width.
- `DUR_G1`, 16: reset duration of G1, in cycles.
- `DUR_NONE1`, 2: reset duration of NONE1, in cycles.
- `DUR_G2`, 2: reset duration of G2, in cycles.
- `DUR_NONE2`, 2: reset duration of NONE2, in cycles.
- `DUR_G3`, 2: reset duration of G3, in cycles.
- `DUR_Y`, 8: reset duration of Y, in cycles.
- `DUR_R`, 16: reset duration of R, in cycles.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `curr_state`  in  8  one-hot phase. Bit order: 0 INIT, 1 G1, 2 NONE1, 3 G2, 4 NONE2, 5 G3, 6 Y, 7 R. This order matches the shared define header.
- `dp_cnt_rst`  in  1  clear phase counter.
- `cfg_valid`  in  1  duration write strobe; single-cycle, no backpressure.
- `cfg_sel`  in  3  target phase: 0 G1, 1 NONE1, 2 G2, 3 NONE2, 4 G3, 5 Y, 6 R; 7 is illegal.
- `cfg_data`  in  CNT_W  new duration.
- `done_state`  out  7  combinational phase-done flags, same order as `cfg_sel`.
- `lamp_r`, `lamp_y`, `lamp_g`  out  1 each  registered lamp drives.
- `cfg_pending`  out  1  shadow bank holds uncommitted writes.
- `cfg_err`  out  1  registered one-cycle pulse on an illegal `cfg_sel`.

## Operation

- **Counter `cnt`:**
  - `rst` or `dp_cnt_rst` → `cnt` <= 0.
  - Otherwise `cnt` <= `cnt`+1, saturating at 2^CNT_W−1.
- **Effective duration `eff_x`:** active duration of phase x; a stored 0 is treated as 1.
- **Done flags:** `done_state[x]` = `curr_state[x]` & (`cnt` == `eff_x`−1).
  - Purely combinational: no `rst` gating, no `dp_cnt_rst` gating.
  - With the controller clearing the counter on done, each phase lasts exactly `eff_x` cycles.
  - Full cycle with defaults = 48 cycles.
- **INIT, or `curr_state` not one-hot** (zero or multiple bits): `done_state` = 0; counter keeps its normal behaviour.
- **Lamps** (next-value from `curr_state`):
  - G1/G2/G3 → G only.
  - Y → Y only.
  - R → R only.
  - NONE1/NONE2, INIT, or non-one-hot → all off (blink gap).
- **Configuration:**
  - `cfg_valid` with `cfg_sel` ≤ 6 → shadow[`cfg_sel`] <= `cfg_data`, and `cfg_pending` <= 1.
  - `cfg_sel` = 7 → no write; `cfg_err` = 1 next cycle.
- **Commit event:** `curr_state[R]` & `done_state[R]`, i.e. the end of a full cycle.
  - On commit: active <= shadow (all 7), and `cfg_pending` <= 0.
  - Durations therefore never change mid-cycle.
- **Write coinciding with commit:** the write lands in shadow only; active takes the pre-write shadow; `cfg_pending` stays 1, and the write applies at the next commit.
- **`pass`** (handled by the controller) returns it to G1 with a counter clear; this block needs no special handling. No commit occurs unless the commit event fires.

## Timing

- Reset values (one cycle after `rst` sampled high):
  - `cnt`=0.
  - active = shadow = parameter defaults.
  - `cfg_pending`=0, `cfg_err`=0.
  - all lamps 0.
- `done_state`: zero latency from `curr_state`/`cnt`; no internal register in this path.
- Lamps: one-cycle latency from `curr_state`.
- Config: write visible in shadow and `cfg_pending` on the next edge. Active update takes effect on the edge of the commit event; the first phase after commit (G1) uses the new values.
- `rst` mid-cycle: discards pending writes and restores defaults.
- `rst` has priority over `cfg_valid`, commit and counting.

## Test plan

- **Default cycle:** reset, closed loop with controller for 96 cycles → G1 16, NONE1 2, G2 2, NONE2 2, G3 2, Y 8, R 16 cycles. Each done pulse is 1 cycle; period is 48. `lamp_g` is low during NONE phases.
- **Reprogram mid-cycle:** write Y=4 (`cfg_sel`=5) during G2 → current Y still 8 cycles and `cfg_pending`=1. The next cycle's Y is 4 cycles and `cfg_pending` clears at the end-of-R edge.
- **Collision and zero duration:**
  - Write G1=0 in the exact commit cycle → next cycle's G1 still 16 cycles and `cfg_pending` stays 1.
  - The following cycle's G1 is 1 cycle long.
- **Illegal select:** `cfg_sel`=7 with `cfg_data`=5 → `cfg_err` pulses 1 cycle; shadow unchanged; `cfg_pending` unchanged.
- **Reset mid-operation:** write R=3, then assert `rst` during Y → after reset R is 16 again, `cfg_pending`=0, `cnt`=0, and lamps are off for one cycle.
- **Saturation and illegal state:**
  - Hold `curr_state`=INIT with no `dp_cnt_rst` for 1100 cycles → `cnt` sticks at 1023 and `done_state` stays 0.
  - Drive `curr_state`=8'h06 (G1 and NONE1 both hot) → `done_state`=0 and lamps off.

Source files
------------

// File: rtl/light_dp.sv
// Traffic-light datapath: phase counter, per-phase duration banks (active + shadow),
// combinational phase-done flags and registered lamp drives.

module light_dp_phase #(
  parameter int               CNT_W = 10,
  parameter logic [CNT_W-1:0] DEF   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_data,
  input  logic             i_commit,
  input  logic             i_hot,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_done
);
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] w_eff;

  // A write in the commit cycle lands in shadow only; active takes the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= DEF;
      r_active <= DEF;
    end else begin
      if (i_commit) r_active <= r_shadow;
      if (i_wr)     r_shadow <= i_data;
    end
  end

  assign w_eff  = (r_active == '0) ? CNT_W'(1) : r_active;
  assign o_done = i_hot && (i_cnt == w_eff - CNT_W'(1));
endmodule

module light_dp #(
  parameter int CNT_W     = 10,
  parameter int DUR_G1    = 16,
  parameter int DUR_NONE1 = 2,
  parameter int DUR_G2    = 2,
  parameter int DUR_NONE2 = 2,
  parameter int DUR_G3    = 2,
  parameter int DUR_Y     = 8,
  parameter int DUR_R     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       curr_state,
  input  logic             dp_cnt_rst,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [6:0]       done_state,
  output logic             lamp_r,
  output logic             lamp_y,
  output logic             lamp_g,
  output logic             cfg_pending,
  output logic             cfg_err
);
  localparam int NPH = 7;
  localparam logic [CNT_W-1:0] DEFS [NPH] = '{
    CNT_W'(DUR_G1), CNT_W'(DUR_NONE1), CNT_W'(DUR_G2), CNT_W'(DUR_NONE2),
    CNT_W'(DUR_G3), CNT_W'(DUR_Y),     CNT_W'(DUR_R)
  };

  logic [CNT_W-1:0] r_cnt;
  logic             r_lamp_r, r_lamp_y, r_lamp_g;
  logic             r_pending, r_err;
  logic             w_onehot;
  logic             w_commit;
  logic             w_cfg_ok;

  assign w_onehot = (curr_state != 8'd0) && ((curr_state & (curr_state - 8'd1)) == 8'd0);
  assign w_cfg_ok = cfg_valid && (cfg_sel != 3'd7);
  // R done is already gated by one-hot R, so it marks the end of a full cycle.
  assign w_commit = done_state[NPH-1];

  genvar g;
  generate
    for (g = 0; g < NPH; g++) begin : g_ph
      light_dp_phase #(.CNT_W(CNT_W), .DEF(DEFS[g])) u_ph (
        .clk      (clk),
        .rst      (rst),
        .i_wr     (w_cfg_ok && (cfg_sel == 3'(g))),
        .i_data   (cfg_data),
        .i_commit (w_commit),
        .i_hot    (w_onehot && curr_state[g+1]),
        .i_cnt    (r_cnt),
        .o_done   (done_state[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || dp_cnt_rst) r_cnt <= '0;
    else if (r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
  end

  // NONE phases, INIT and illegal encodings all blank the lamps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lamp_r <= 1'b0;
      r_lamp_y <= 1'b0;
      r_lamp_g <= 1'b0;
    end else begin
      r_lamp_r <= w_onehot && curr_state[7];
      r_lamp_y <= w_onehot && curr_state[6];
      r_lamp_g <= w_onehot && (curr_state[1] || curr_state[3] || curr_state[5]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= cfg_valid && (cfg_sel == 3'd7);
      if (w_cfg_ok)      r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
    end
  end

  assign lamp_r      = r_lamp_r;
  assign lamp_y      = r_lamp_y;
  assign lamp_g      = r_lamp_g;
  assign cfg_pending = r_pending;
  assign cfg_err     = r_err;
endmodule

// File: tb/tb_light_dp.sv
// Bench for light_dp: closed-loop controller model plus a phase-level reference model.
module tb_light_dp;
  localparam int CW = 10;
  localparam int DEF [7] = '{16, 2, 2, 2, 2, 8, 16};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    curr_state = 8'd0;
  logic          dp_cnt_rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [2:0]    cfg_sel = 3'd0;
  logic [CW-1:0] cfg_data = '0;
  logic [6:0]    done_state;
  logic          lamp_r, lamp_y, lamp_g, cfg_pending, cfg_err;

  always #5 clk = ~clk;

  light_dp dut (
    .clk(clk), .rst(rst), .curr_state(curr_state), .dp_cnt_rst(dp_cnt_rst),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .done_state(done_state), .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  int n_cmp = 0, n_fail = 0;
  int m_cnt = 0;
  int m_act [7] = DEF;
  int m_sh  [7] = DEF;
  logic m_pend = 1'b0, m_err = 1'b0;
  logic [2:0] m_lamp = 3'd0;   // {r, y, g}
  int plen = 0;
  int last_len [7] = '{0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [6:0] mdone();
    logic [6:0] d = '0;
    if ($countones(curr_state) == 1 && !curr_state[0])
      for (int i = 0; i < 7; i++)
        if (curr_state[i+1] && m_cnt == eff(m_act[i]) - 1) d[i] = 1'b1;
    return d;
  endfunction

  task automatic model_edge(input logic [6:0] d);
    logic oh;
    if (rst) begin
      m_cnt = 0; m_act = DEF; m_sh = DEF;
      m_pend = 1'b0; m_err = 1'b0; m_lamp = 3'd0;
    end else begin
      oh = ($countones(curr_state) == 1);
      m_lamp = oh ? {curr_state[7], curr_state[6], curr_state[1] | curr_state[3] | curr_state[5]} : 3'd0;
      m_cnt = dp_cnt_rst ? 0 : ((m_cnt == 1023) ? 1023 : m_cnt + 1);
      m_err = cfg_valid && cfg_sel == 3'd7;
      if (d[6]) begin m_act = m_sh; m_pend = 1'b0; end
      if (cfg_valid && cfg_sel != 3'd7) begin m_sh[cfg_sel] = int'(cfg_data); m_pend = 1'b1; end
    end
  endtask

  // One clock: check done before the edge, then registered outputs after it.
  // With ctl set the bench acts as the controller: clear on done, advance phase.
  task automatic tick(input logic ctl);
    logic [6:0] d;
    #1;
    d = mdone();
    chk("done_state", 32'(done_state), 32'(d));
    if (ctl) dp_cnt_rst = |d;
    model_edge(d);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk("lamps", 32'({lamp_r, lamp_y, lamp_g}), 32'(m_lamp));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    if (ctl) begin
      plen++;
      if (|d) begin
        for (int i = 0; i < 7; i++) if (d[i]) last_len[i] = plen;
        plen = 0;
        curr_state = (curr_state == 8'h80) ? 8'h02 : (curr_state << 1);
      end
    end
  endtask

  task automatic run_until(input logic [7:0] target);
    int k = 0;
    while (curr_state != target && k < 200) begin tick(1'b1); k++; end
    chk("reach_state", 32'(curr_state), 32'(target));
  endtask

  task automatic cfg(input int sel, input int data);
    cfg_valid = 1'b1; cfg_sel = 3'(sel); cfg_data = CW'(data);
  endtask

  initial begin
    int k;
    // reset
    rst = 1'b1; tick(1'b0); rst = 1'b0;
    chk("rst_cnt", 32'(dut.r_cnt), 0);

    // default cycle from G1
    curr_state = 8'h02; plen = 0;
    run_until(8'h80); run_until(8'h02);
    for (int i = 0; i < 7; i++) chk($sformatf("default_len%0d", i), last_len[i], DEF[i]);
    run_until(8'h80); run_until(8'h02);
    chk("default_period", last_len.sum(), 48);

    // reprogram Y=4 during G2
    run_until(8'h08);
    cfg(5, 4); tick(1'b1);
    chk("pend_after_wr", 32'(cfg_pending), 1);
    run_until(8'h80); run_until(8'h02);
    chk("y_len_old", last_len[5], 8);
    chk("pend_cleared", 32'(cfg_pending), 0);
    run_until(8'h80); run_until(8'h02);
    chk("y_len_new", last_len[5], 4);

    // write G1=0 exactly in the commit cycle
    run_until(8'h80);
    k = 0;
    while (m_cnt != eff(m_act[6]) - 1 && k < 50) begin tick(1'b1); k++; end
    cfg(0, 0); tick(1'b1);
    chk("collide_pend", 32'(cfg_pending), 1);
    run_until(8'h80); run_until(8'h02);
    chk("collide_g1_old", last_len[0], 16);
    run_until(8'h04);
    chk("g1_zero_len", last_len[0], 1);
    chk("pend_after_commit", 32'(cfg_pending), 0);

    // illegal select
    cfg(7, 5); tick(1'b1);
    chk("err_pulse", 32'(cfg_err), 1);
    tick(1'b1);
    chk("err_clear", 32'(cfg_err), 0);

    // reset during Y discards pending R=3
    cfg(6, 3); tick(1'b1);
    run_until(8'h40); tick(1'b1);
    rst = 1'b1; dp_cnt_rst = 1'b0; tick(1'b0); rst = 1'b0;
    chk("rst_mid_cnt", 32'(dut.r_cnt), 0);
    chk("rst_mid_lamps", 32'({lamp_r, lamp_y, lamp_g}), 0);
    curr_state = 8'h02; plen = 0;
    run_until(8'h80); run_until(8'h02);
    chk("r_len_restored", last_len[6], 16);
    chk("g1_len_restored", last_len[0], 16);

    // randomized writes in closed loop (short durations keep cycles brief)
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) cfg($urandom_range(0, 7), $urandom_range(0, 5));
      tick(1'b1);
    end

    // counter saturation in INIT
    curr_state = 8'h01; dp_cnt_rst = 1'b0;
    repeat (1100) tick(1'b0);
    chk("cnt_sat", 32'(dut.r_cnt), 1023);

    // two phases hot at once
    curr_state = 8'h06; dp_cnt_rst = 1'b1; tick(1'b0);
    dp_cnt_rst = 1'b0;
    repeat (4) tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
